// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared constants and TX state encoding for the UART word bridge
package uart_bridge_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_word_fifo.sv
// rtl/uart_word_fifo.sv - synchronous word FIFO with registered full/empty flags
module uart_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Flags are registered from the next count so they change on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_word_bridge.sv
// rtl/uart_word_bridge.sv - packs UART bytes into 32-bit command words and serializes response words
module uart_word_bridge #(
  parameter int          FIFO_DEPTH        = 4,
  parameter int unsigned RX_TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_ready,
  output logic        uart_rx_empty,
  output logic        uart_tx_empty,
  input  logic        uart_read,
  output logic        uart_read_response,
  output logic [31:0] uart_read_data,
  input  logic        uart_write,
  input  logic [31:0] uart_write_data,
  output logic        uart_write_response,
  output logic        rx_overflow
);

  import uart_bridge_pkg::*;

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W = (RX_TIMEOUT_CYCLES > 1) ? $clog2(RX_TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (RX_TIMEOUT_CYCLES != 0);

  logic [1:0]        byte_idx;
  logic [23:0]       asm_low;
  logic              push_pend;
  logic [WORD_W-1:0] push_word;
  logic [TO_W-1:0]   to_cnt;
  logic              to_expired;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [WORD_W-1:0] fifo_head;
  logic              read_q;
  logic              rd_accept;

  tx_state_t         tx_state;
  logic [WORD_W-1:0] tx_word;
  logic [1:0]        tx_idx;

  assign to_expired = TO_EN && ((32'(to_cnt) + 32'd1) >= RX_TIMEOUT_CYCLES);
  assign rd_accept  = uart_read & ~read_q & ~fifo_empty;
  assign uart_rx_empty = fifo_empty;

  uart_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_pend),
    .push_data (push_word),
    .pop       (rd_accept),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Byte lanes 0..2 are staged; the 4th byte completes the word and schedules a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx    <= 2'd0;
      asm_low     <= '0;
      push_pend   <= 1'b0;
      push_word   <= '0;
      to_cnt      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (push_pend && fifo_full) rx_overflow <= 1'b1;
      if (rx_byte_valid) begin
        to_cnt   <= '0;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: asm_low[7:0]   <= rx_byte;
          2'd1: asm_low[15:8]  <= rx_byte;
          2'd2: asm_low[23:16] <= rx_byte;
          default: begin
            push_word <= {rx_byte, asm_low};
            push_pend <= 1'b1;
          end
        endcase
      end else if (TO_EN && byte_idx != 2'd0) begin
        if (to_expired) begin
          byte_idx <= 2'd0;
          to_cnt   <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // A held uart_read only pops once: acceptance needs the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q             <= 1'b0;
      uart_read_response <= 1'b0;
      uart_read_data     <= '0;
    end else begin
      read_q             <= uart_read;
      uart_read_response <= rd_accept;
      if (rd_accept) uart_read_data <= fifo_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state            <= TX_IDLE;
      tx_word             <= '0;
      tx_idx              <= 2'd0;
      tx_byte             <= 8'd0;
      tx_byte_valid       <= 1'b0;
      uart_tx_empty       <= 1'b1;
      uart_write_response <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_write_response <= 1'b0;
          if (uart_write) begin
            tx_word       <= uart_write_data;
            tx_idx        <= 2'd0;
            tx_byte       <= uart_write_data[7:0];
            tx_byte_valid <= 1'b1;
            uart_tx_empty <= 1'b0;
            tx_state      <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            if (tx_idx == 2'd3) begin
              tx_byte             <= 8'd0;
              tx_byte_valid       <= 1'b0;
              uart_write_response <= 1'b1;
              tx_state            <= TX_DONE;
            end else begin
              tx_idx <= tx_idx + 2'd1;
              case (tx_idx)
                2'd0:    tx_byte <= tx_word[15:8];
                2'd1:    tx_byte <= tx_word[23:16];
                default: tx_byte <= tx_word[31:24];
              endcase
            end
          end
        end
        TX_DONE: begin
          uart_write_response <= 1'b0;
          uart_tx_empty       <= 1'b1;
          tx_state            <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// tb/tb_uart_word_bridge.sv - directed self-checking bench for uart_word_bridge
module tb_uart_word_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_ready;
  logic        uart_rx_empty;
  logic        uart_tx_empty;
  logic        uart_read;
  logic        uart_read_response;
  logic [31:0] uart_read_data;
  logic        uart_write;
  logic [31:0] uart_write_data;
  logic        uart_write_response;
  logic        rx_overflow;

  int tests = 0;
  int fails = 0;

  uart_word_bridge #(
    .FIFO_DEPTH        (4),
    .RX_TIMEOUT_CYCLES (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_byte             (rx_byte),
    .rx_byte_valid       (rx_byte_valid),
    .tx_byte             (tx_byte),
    .tx_byte_valid       (tx_byte_valid),
    .tx_ready            (tx_ready),
    .uart_rx_empty       (uart_rx_empty),
    .uart_tx_empty       (uart_tx_empty),
    .uart_read           (uart_read),
    .uart_read_response  (uart_read_response),
    .uart_read_data      (uart_read_data),
    .uart_write          (uart_write),
    .uart_write_data     (uart_write_data),
    .uart_write_response (uart_write_response),
    .rx_overflow         (rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  // Sends LSB first, then idles one cycle so the push has landed.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] sh;
      sh = w >> (8 * i);
      send_byte(sh[7:0]);
    end
    tick();
  endtask

  task automatic do_read(input string tag, input int exp_resp, input logic [31:0] exp_word);
    int          resp;
    logic [31:0] got;
    resp = 0;
    got  = '0;
    uart_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (uart_read_response) begin
        resp++;
        got = uart_read_data;
      end
    end
    uart_read = 1'b0;
    tick();
    if (uart_read_response) resp++;
    check({tag, "_resp_count"}, resp, exp_resp);
    if (exp_resp != 0) check({tag, "_data"}, got, exp_word);
  endtask

  task automatic do_write(input string tag, input logic [31:0] w, input logic [7:0] pat,
                          input bit mid_write, input int exp_resp_k);
    int n;
    int k;
    int resp_k;
    logic [31:0] sh;
    n      = 0;
    k      = 0;
    resp_k = -1;
    uart_write      = 1'b1;
    uart_write_data = w;
    tick();
    uart_write = 1'b0;
    while (resp_k < 0 && k < 30) begin
      tx_ready = (k < 8) ? pat[k] : 1'b1;
      if (mid_write && k == 2) begin
        uart_write      = 1'b1;
        uart_write_data = 32'h12345678;
      end else begin
        uart_write = 1'b0;
      end
      if (uart_write_response) begin
        resp_k = k;
      end else if (tx_byte_valid) begin
        sh = w >> (8 * n);
        check({tag, "_byte"}, {24'd0, tx_byte}, {24'd0, sh[7:0]});
        if (tx_ready) n++;
      end
      tick();
      k++;
    end
    uart_write = 1'b0;
    tx_ready   = 1'b1;
    check({tag, "_bytes_accepted"}, n, 4);
    check({tag, "_resp_cycle"}, resp_k, exp_resp_k);
    check({tag, "_resp_pulse_width"}, {31'd0, uart_write_response}, 32'd0);
    check({tag, "_tx_empty_after"}, {31'd0, uart_tx_empty}, 32'd1);
  endtask

  initial begin
    rst_n           = 1'b0;
    rx_byte         = 8'd0;
    rx_byte_valid   = 1'b0;
    tx_ready        = 1'b1;
    uart_read       = 1'b0;
    uart_write      = 1'b0;
    uart_write_data = 32'd0;
    #23;
    check("rst_rx_empty", {31'd0, uart_rx_empty}, 32'd1);
    check("rst_tx_empty", {31'd0, uart_tx_empty}, 32'd1);
    check("rst_tx_valid", {31'd0, tx_byte_valid}, 32'd0);
    check("rst_read_data", uart_read_data, 32'd0);
    check("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word, held read gives one response.
    send_word(32'h00000070);
    check("rx1_not_empty", {31'd0, uart_rx_empty}, 32'd0);
    do_read("rx1", 1, 32'h00000070);
    check("rx1_empty_after", {31'd0, uart_rx_empty}, 32'd1);
    do_read("rd_on_empty", 0, 32'd0);

    do_write("tx1", 32'h0000006A, 8'hFF, 1'b0, 4);

    // Partial word abandoned by timeout.
    send_byte(8'h43);
    send_byte(8'h11);
    repeat (20) tick();
    send_word(32'h03020157);
    do_read("timeout", 1, 32'h03020157);

    // Five words into a four-deep FIFO.
    check("ovf_clear_before", {31'd0, rx_overflow}, 32'd0);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    check("ovf_clear_at_full", {31'd0, rx_overflow}, 32'd0);
    send_word(32'h55555555);
    check("ovf_set", {31'd0, rx_overflow}, 32'd1);
    do_read("ovf_w0", 1, 32'h11111111);
    do_read("ovf_w1", 1, 32'h22222222);
    do_read("ovf_w2", 1, 32'h33333333);
    do_read("ovf_w3", 1, 32'h44444444);
    check("ovf_drained", {31'd0, uart_rx_empty}, 32'd1);
    check("ovf_sticky", {31'd0, rx_overflow}, 32'd1);

    do_write("tx2", 32'hDEADBEEF, 8'hD9, 1'b1, 7);

    // Reset with a queued word, a partial word and a stalled TX in flight.
    send_word(32'h99887766);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tx_ready        = 1'b0;
    uart_write      = 1'b1;
    uart_write_data = 32'hCAFEF00D;
    tick();
    uart_write = 1'b0;
    tick();
    check("pre_rst_tx_valid", {31'd0, tx_byte_valid}, 32'd1);
    check("pre_rst_rx_empty", {31'd0, uart_rx_empty}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", {31'd0, tx_byte_valid}, 32'd0);
    check("arst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("arst_tx_empty", {31'd0, uart_tx_empty}, 32'd1);
    check("arst_rx_empty", {31'd0, uart_rx_empty}, 32'd1);
    check("arst_overflow", {31'd0, rx_overflow}, 32'd0);
    check("arst_read_data", uart_read_data, 32'd0);
    tx_ready = 1'b1;
    #7;
    rst_n = 1'b1;
    tick();
    send_word(32'hA1B2C3D4);
    do_read("post_rst", 1, 32'hA1B2C3D4);
    check("post_rst_empty", {31'd0, uart_rx_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
